// File: rtl/id_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_scheduler
// Purpose  : ID-stage issue/hazard controller: load-use scoreboard, stall and
//            flush sequencing, optional saturating statistics (HAZ_PERF_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module id_hazard_scheduler #(
   parameter int NUM_REGS     = 32,
   parameter int LOAD_LAT     = 2,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             branch_taken,
   input  logic             jump,
   output logic             Data_Hazard,
   output logic             Control_Hazard,
   output logic             issue,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int SB_W = $clog2(LOAD_LAT + 1);
   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_STALL = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [SB_W-1:0] sb_q [NUM_REGS];
   logic [SB_W-1:0] sb_d [NUM_REGS];
   logic [1:0]      state_q, state_d;
   logic [FC_W-1:0] fcnt_q, fcnt_d;

   logic w_rs1_busy, w_rs2_busy, w_hz, w_in_flush, w_redirect, w_load_set;

   // Hazard lookup uses the registered scoreboard only, so a load is seen from the next edge
   assign w_rs1_busy = id_uses_rs1 && (id_rs1 != 5'd0) && (sb_q[id_rs1] != '0);
   assign w_rs2_busy = id_uses_rs2 && (id_rs2 != 5'd0) && (sb_q[id_rs2] != '0);
   assign w_hz       = id_valid && (w_rs1_busy || w_rs2_busy);
   assign w_in_flush = (state_q == S_FLUSH);
   assign w_redirect = issue && (branch_taken || jump);
   assign w_load_set = issue && id_mem_read && id_reg_write && (id_rd != 5'd0);

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         sb_d[i] = (sb_q[i] != '0) ? (sb_q[i] - SB_W'(1)) : '0;
         if (w_load_set && (id_rd == 5'(i)) && (i != 0)) begin
            sb_d[i] = SB_W'(LOAD_LAT);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            sb_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            sb_q[i] <= sb_d[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // RUN and STALL share transitions: a data hazard always wins over a redirect
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         S_RUN, S_STALL: begin
            if (w_hz) begin
               state_d = S_STALL;
            end else if (w_redirect) begin
               state_d = S_FLUSH;
               fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            end else begin
               state_d = S_RUN;
            end
         end
         S_FLUSH: begin
            if (fcnt_q == '0) begin
               state_d = S_RUN;
            end else begin
               fcnt_d = fcnt_q - FC_W'(1);
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      Data_Hazard    = w_hz && !w_in_flush;
      issue          = id_valid && !w_hz && !w_in_flush;
      Control_Hazard = w_in_flush;
      state          = state_q;
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             w_flush_entry;

   assign w_flush_entry = (state_d == S_FLUSH) && (state_q != S_FLUSH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (Data_Hazard && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (w_flush_entry && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule
`default_nettype wire
